led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Downstream consumer of the 5 Hz blink divider. Runs on the 100 MHz system clock, detects rising edges of the divided `blink_in` level, and advances an LED pattern (off, all-blink, chaser, ping-pong) once per edge. Pattern mode is selectable at run time, and changes take effect only on a step boundary. Drives the board LED bank and exposes a step pulse and counter for debug.

## Interface
- `LED_COUNT`, default 8: number of LEDs driven; legal range 2..32.
- `clock_in`  input  1  system clock (100 MHz); all logic on its rising edge.
- `reset_in`  input  1  synchronous, active-high reset.
- `blink_in`  input  1  divided slow clock level from the blink divider (the divider's `clock_out`).
- `mode_in`  input  2  pattern select: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE.
- `led_out`  output  LED_COUNT  LED drive, registered.
- `step_pulse_out`  output  1  one-cycle pulse, high in the same cycle `led_out` takes a new value.
- `step_count_out`  output  8  count of steps since reset, registered.

## Operation
- Edge detect: `blink_d` register holds the previous sample; step = `blink_in & ~blink_d`. Only rising edges step; falling edges are ignored.
- States: IDLE (OFF), BLINK, CHASE, BOUNCE_UP, BOUNCE_DOWN.
- `mode_in` is sampled only on a step. Between steps it is ignored.
- Mode change: on a step whose `mode_in` differs from the current state's mode, load the initial pattern:
  - OFF loads 0.
  - BLINK loads all ones.
  - CHASE loads 1 (bit 0).
  - BOUNCE loads 1 and enters BOUNCE_UP.
- Same mode, per step:
  - OFF: holds 0.
  - BLINK: `led_out` inverted.
  - CHASE: rotate left by 1; bit LED_COUNT-1 wraps to bit 0.
  - BOUNCE_UP: if `led_out[LED_COUNT-1]`, shift right and go to BOUNCE_DOWN; else shift left.
  - BOUNCE_DOWN: if `led_out[0]`, shift left and go to BOUNCE_UP; else shift right.
  - Result for LED_COUNT=8: 1,2,4,…,128,64,…,1,2. End LEDs are lit for one step only.
- Mode 3 maps to both BOUNCE_UP and BOUNCE_DOWN. Staying on mode 3 never reloads the pattern.
- `step_count_out`: +1 on every step in every mode, wraps 255→0.
- Exactly one LED is lit at all times in CHASE and BOUNCE.

## Timing
- Reset values: `led_out`=0, `step_pulse_out`=0, `step_count_out`=0, state IDLE, `blink_d`=1, sync flops=1.
  - Because `blink_d` resets to 1, a `blink_in` already high at reset release does not step.
  - The first step occurs on the first genuine 0→1 transition.
- Latency: when `blink_in` is first sampled high at clock edge k, `led_out`, `step_count_out` and `step_pulse_out` update at edge k+1. `step_pulse_out` deasserts at edge k+2.
- Minimum step spacing: 2 cycles. A `blink_in` pattern of 0,1,0,1 produces two steps.
- Reset has priority: if `reset_in` is high in a step cycle, the step is discarded and all registers take reset values.
- Reset mid-pattern: the pattern restarts from IDLE. The next step loads the initial pattern for `mode_in`.
- Holding `blink_in` high for any number of cycles produces one step only.

## Configuration
- `LED_SEQ_SYNC_EN` defined: `blink_in` passes through a 2-flop synchronizer (both flops reset to 1) before edge detection.
  - Latency becomes 3 cycles: input sampled high at edge k, outputs update at edge k+3.
  - Use when `blink_in` comes from another clock domain or a pin.
- `LED_SEQ_SYNC_EN` undefined: no synchronizer; 1-cycle latency as in Timing. This is legal only with the on-chip divider in the same `clock_in` domain.

## Test plan
- Reset with `blink_in`=1 held for 10 cycles after release → no `step_pulse_out`, `led_out`=0, `step_count_out`=0. Then drop `blink_in` and raise it → one step, `step_count_out`=1.
- `mode_in`=2, LED_COUNT=8, 9 rising edges → `led_out` 0x01,0x02,…,0x80,0x01. Each value appears exactly 1 cycle after the rising edge (3 cycles with `LED_SEQ_SYNC_EN`).
- `mode_in`=3, 16 steps → `led_out` 0x01,0x02,…,0x80,0x40,…,0x01,0x02. Assert `$onehot(led_out)` throughout.
- `mode_in`=1 for 3 steps → 0xFF,0x00,0xFF. Switch to 2 mid-step with no edge → `led_out` holds 0xFF; next edge → 0x01.
- 260 steps in mode 0 → `led_out` stays 0, `step_count_out` wraps to 4, one `step_pulse_out` per edge and none on falling edges.
- `reset_in` asserted in the same cycle as a step during CHASE at 0x10 → next cycle `led_out`=0, `step_count_out`=0, `step_pulse_out`=0.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps an OFF/BLINK/CHASE/BOUNCE pattern on each rising edge of blink_in.
// Optional define LED_SEQ_SYNC_EN inserts a 2-flop synchronizer ahead of edge detection.
//
// state          | meaning
// ST_IDLE        | mode 0, LEDs held off
// ST_BLINK       | mode 1, all LEDs toggle each step
// ST_CHASE       | mode 2, single lit LED rotates left
// ST_BOUNCE_UP   | mode 3, lit LED moving toward the MSB
// ST_BOUNCE_DOWN | mode 3, lit LED moving toward the LSB
module led_pattern_sequencer #(
  parameter int LED_COUNT = 8
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 blink_in,
  input  logic [1:0]           mode_in,
  output logic [LED_COUNT-1:0] led_out,
  output logic                 step_pulse_out,
  output logic [7:0]           step_count_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLINK,
    ST_CHASE,
    ST_BOUNCE_UP,
    ST_BOUNCE_DOWN
  } state_t;

  localparam logic [LED_COUNT-1:0] LedOne = {{(LED_COUNT-1){1'b0}}, 1'b1};

  state_t                 state_q;
  logic [LED_COUNT-1:0]   led_q;
  logic                   step_pulse_q;
  logic [7:0]             step_count_q;
  logic                   blink_s;
  logic                   sample_q;
  logic                   blink_d_q;
  logic                   step;
  logic [1:0]             cur_mode;
  logic [LED_COUNT-1:0]   rot_left_d;
  logic [LED_COUNT-1:0]   shl_d;
  logic [LED_COUNT-1:0]   shr_d;

`ifdef LED_SEQ_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= blink_in;
      sync2_q <= sync1_q;
    end
  end

  assign blink_s = sync2_q;
`else
  assign blink_s = blink_in;
`endif

  // Both sample flops reset high so a level already high at release never steps.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      sample_q  <= 1'b1;
      blink_d_q <= 1'b1;
    end else begin
      sample_q  <= blink_s;
      blink_d_q <= sample_q;
    end
  end

  assign step = sample_q & ~blink_d_q;

  always_comb begin
    cur_mode = 2'd0;
    case (state_q)
      ST_IDLE:        cur_mode = 2'd0;
      ST_BLINK:       cur_mode = 2'd1;
      ST_CHASE:       cur_mode = 2'd2;
      ST_BOUNCE_UP:   cur_mode = 2'd3;
      ST_BOUNCE_DOWN: cur_mode = 2'd3;
      default:        cur_mode = 2'd0;
    endcase
  end

  assign rot_left_d = {led_q[LED_COUNT-2:0], led_q[LED_COUNT-1]};
  assign shl_d      = led_q << 1;
  assign shr_d      = led_q >> 1;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= ST_IDLE;
      led_q        <= '0;
      step_pulse_q <= 1'b0;
      step_count_q <= 8'd0;
    end else begin
      step_pulse_q <= step;
      if (step) begin
        step_count_q <= step_count_q + 8'd1;
        if (mode_in != cur_mode) begin
          case (mode_in)
            2'd0: begin state_q <= ST_IDLE;      led_q <= '0;     end
            2'd1: begin state_q <= ST_BLINK;     led_q <= '1;     end
            2'd2: begin state_q <= ST_CHASE;     led_q <= LedOne; end
            2'd3: begin state_q <= ST_BOUNCE_UP; led_q <= LedOne; end
            default: begin state_q <= ST_IDLE;   led_q <= '0;     end
          endcase
        end else begin
          case (state_q)
            ST_IDLE:  led_q <= '0;
            ST_BLINK: led_q <= ~led_q;
            ST_CHASE: led_q <= rot_left_d;
            ST_BOUNCE_UP: begin
              if (led_q[LED_COUNT-1]) begin
                led_q   <= shr_d;
                state_q <= ST_BOUNCE_DOWN;
              end else begin
                led_q <= shl_d;
              end
            end
            ST_BOUNCE_DOWN: begin
              if (led_q[0]) begin
                led_q   <= shl_d;
                state_q <= ST_BOUNCE_UP;
              end else begin
                led_q <= shr_d;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              led_q   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign led_out        = led_q;
  assign step_pulse_out = step_pulse_q;
  assign step_count_out = step_count_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed, table-driven bench for led_pattern_sequencer (LED_COUNT=8, no synchronizer).
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blink = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] led;
  logic       pulse;
  logic [7:0] cnt;

  int checks = 0;
  int failures = 0;
  int pulse_seen = 0;
  logic [7:0] exp_cnt = 8'd0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] led;
  } vec_t;

  vec_t vecs[$];

  led_pattern_sequencer #(.LED_COUNT(8)) dut (
    .clock_in      (clk),
    .reset_in      (rst),
    .blink_in      (blink),
    .mode_in       (mode),
    .led_out       (led),
    .step_pulse_out(pulse),
    .step_count_out(cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pulse) pulse_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
  endtask

  // One full low/high blink period; checks latency, value and pulse width.
  task automatic step(input logic [1:0] m, input logic [7:0] exp_led, input string name);
    logic [7:0] prev;
    mode  = m;
    blink = 1'b0;
    tick();
    tick();
    prev  = led;
    blink = 1'b1;
    tick();
    chk({name, "_pre_pulse"}, 32'(pulse), 32'd0);
    chk({name, "_pre_led"}, 32'(led), 32'(prev));
    tick();
    exp_cnt = exp_cnt + 8'd1;
    chk({name, "_led"}, 32'(led), 32'(exp_led));
    chk({name, "_pulse"}, 32'(pulse), 32'd1);
    chk({name, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    tick();
    chk({name, "_post_pulse"}, 32'(pulse), 32'd0);
  endtask

  initial begin
    int start_pulses;
    bit led_ok;

    vecs.push_back('{2'd2, 8'h01}); vecs.push_back('{2'd2, 8'h02});
    vecs.push_back('{2'd2, 8'h04}); vecs.push_back('{2'd2, 8'h08});
    vecs.push_back('{2'd2, 8'h10}); vecs.push_back('{2'd2, 8'h20});
    vecs.push_back('{2'd2, 8'h40}); vecs.push_back('{2'd2, 8'h80});
    vecs.push_back('{2'd2, 8'h01});
    vecs.push_back('{2'd3, 8'h01}); vecs.push_back('{2'd3, 8'h02});
    vecs.push_back('{2'd3, 8'h04}); vecs.push_back('{2'd3, 8'h08});
    vecs.push_back('{2'd3, 8'h10}); vecs.push_back('{2'd3, 8'h20});
    vecs.push_back('{2'd3, 8'h40}); vecs.push_back('{2'd3, 8'h80});
    vecs.push_back('{2'd3, 8'h40}); vecs.push_back('{2'd3, 8'h20});
    vecs.push_back('{2'd3, 8'h10}); vecs.push_back('{2'd3, 8'h08});
    vecs.push_back('{2'd3, 8'h04}); vecs.push_back('{2'd3, 8'h02});
    vecs.push_back('{2'd3, 8'h01}); vecs.push_back('{2'd3, 8'h02});
    vecs.push_back('{2'd1, 8'hFF}); vecs.push_back('{2'd1, 8'h00});
    vecs.push_back('{2'd1, 8'hFF});

    // Reset, then blink held high after release must not step.
    rst   = 1'b1;
    blink = 1'b1;
    tick();
    tick();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    rst = 1'b0;
    start_pulses = pulse_seen;
    repeat (10) tick();
    chk("hold_high_pulses", 32'(pulse_seen - start_pulses), 32'd0);
    chk("hold_high_led", 32'(led), 32'd0);
    chk("hold_high_cnt", 32'(cnt), 32'd0);
    step(2'd0, 8'h00, "first_edge");

    foreach (vecs[i]) begin
      step(vecs[i].mode, vecs[i].led, $sformatf("vec%0d", i));
      if (vecs[i].mode >= 2'd2)
        chk($sformatf("vec%0d_onehot", i), 32'($onehot(led)), 32'd1);
    end

    // Mode change without an edge is ignored until the next step.
    mode = 2'd2;
    repeat (6) tick();
    chk("mode_no_edge_led", 32'(led), 32'hFF);
    step(2'd2, 8'h01, "mode_switch_edge");

    // Long OFF run: counter wraps and one pulse per rising edge only.
    do_reset();
    start_pulses = pulse_seen;
    led_ok = 1'b1;
    for (int i = 0; i < 260; i++) begin
      step(2'd0, 8'h00, "off_run");
      if (led !== 8'h00) led_ok = 1'b0;
    end
    chk("off_led_stayed_zero", 32'(led_ok), 32'd1);
    chk("off_cnt_wrap", 32'(cnt), 32'd4);
    chk("off_pulse_total", 32'(pulse_seen - start_pulses), 32'd260);

    // Reset in the same cycle as a step while chasing at 0x10.
    do_reset();
    step(2'd2, 8'h01, "rst_chase1");
    step(2'd2, 8'h02, "rst_chase2");
    step(2'd2, 8'h04, "rst_chase3");
    step(2'd2, 8'h08, "rst_chase4");
    step(2'd2, 8'h10, "rst_chase5");
    blink = 1'b0;
    tick();
    tick();
    blink = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_step_led", 32'(led), 32'd0);
    chk("rst_step_cnt", 32'(cnt), 32'd0);
    chk("rst_step_pulse", 32'(pulse), 32'd0);
    rst = 1'b0;
    exp_cnt = 8'd0;
    tick();
    tick();
    chk("rst_release_high_pulse", 32'(pulse), 32'd0);
    step(2'd2, 8'h01, "rst_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
